ahb_lite_sram_responder: RTL and testbench
==========================================

// Module: ahb_lite_sram_responder
// PURPOSE
//   AHB-Lite slave (responder) backed by a word-organised SRAM array. It sits on the SLAVE side of the
//   testbench/system AHB interface and answers a Cortex-M3 or UVM master. It provides programmable
//   wait states, byte/halfword/word accesses and an optional two-cycle ERROR response. It is the
//   data-phase counterpart to the master-side drivers.
// PARAMETERS
//   MEM_BYTES    4096        SRAM size in bytes; power of two, >=4; addresses wrap modulo MEM_BYTES
//   WAIT_STATES  0           HREADYOUT-low cycles inserted at the start of every OKAY data phase (0..15)
//   ERR_BASE     32'hF000    first byte address answered with ERROR (AHB_SLV_ERR_RESP_EN only)
//   ERR_BYTES    256         size of the ERROR window in bytes (AHB_SLV_ERR_RESP_EN only)
// PORTS
//   hclk       in   1   bus clock; all state changes on the rising edge
//   hresetn    in   1   asynchronous active-low reset
//   HSEL       in   1   slave select from the decoder
//   HADDR      in   32  byte address (address phase)
//   HWRITE     in   1   1 = write
//   HTRANS     in   2   IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
//   HSIZE      in   3   0 = byte, 1 = half, 2 = word; >2 is treated as word
//   HBURST     in   3   ignored; each beat is handled independently
//   HPROT      in   4   ignored
//   HWDATA     in   32  write data (data phase)
//   HREADY     in   1   bus-level ready; address phase sampled only when 1
//   HREADYOUT  out  1   slave ready
//   HRESP      out  1   0 = OKAY, 1 = ERROR
//   HRDATA     out  32  read data
// BEHAVIOUR
//   - Reset (asynchronous, any cycle): state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0.
//     Any pending write is dropped; SRAM contents are kept, not cleared.
//   - Address phase is accepted when HSEL & HREADY & HTRANS[1]. The block registers addr, write, size,
//     and a byte-lane mask built from HSIZE and HADDR[1:0] (little-endian).
//     IDLE/BUSY/unselected beats get a zero-wait OKAY and cause no state change.
//   - States: IDLE -> (accepted beat) WAIT if WAIT_STATES>0, else DATA. WAIT counts WAIT_STATES cycles
//     with HREADYOUT=0, HRESP=0, then moves to DATA. DATA: HREADYOUT=1, HRESP=0.
//     The next state comes from that same cycle's address phase (back-to-back beats allowed).
//   - Write: the masked HWDATA lanes commit to mem[addr[AW-1:2]] on the edge that ends DATA.
//     A read data phase that directly follows a write to the same word returns the new data.
//   - Read: HRDATA = mem word at the registered address while in DATA with a read pending, otherwise 0.
//     All 4 lanes are driven; the master picks the relevant lanes.
//   - Misaligned accesses (word with addr[1:0]!=0, half with addr[0]=1):
//     * without the macro, the low address bits are masked to the natural alignment;
//     * with the macro, they get ERROR.
//   - Simultaneous events: a new address phase arriving during the final DATA cycle is accepted.
//     An address phase offered while HREADY=0 is ignored.
// CONFIGURATION
//   AHB_SLV_ERR_RESP_EN defined:
//     - A beat that hits [ERR_BASE, ERR_BASE+ERR_BYTES) or is misaligned enters ERR1, then ERR2.
//       * ERR1: HREADYOUT=0, HRESP=1.
//       * ERR2: HREADYOUT=1, HRESP=1.
//     - No wait states are inserted, the write is suppressed, and HRDATA=0.
//     - An address phase offered during ERR1 is ignored (HREADY=0). One offered during ERR2 is accepted.
//   AHB_SLV_ERR_RESP_EN not defined: no ERR states, HRESP tied 0, all beats complete OKAY.
// STRUCTURE
//   - Package ahb_pkg: htrans_e (IDLE/BUSY/NONSEQ/SEQ), hsize_e (BYTE/HALF/WORD), hresp_e (OKAY/ERROR),
//     and the slave state enum slv_state_e (IDLE/WAIT/DATA/ERR1/ERR2).
//   - Sub-module ahb_byte_lane_decode: combinational HSIZE + HADDR[1:0] -> 4-bit lane mask + misalign flag.
// TESTING
//   1. WAIT_STATES=0: NONSEQ word write 0x100 <= 0xDEADBEEF, then read 0x100 -> HRDATA=0xDEADBEEF,
//      HREADYOUT stays 1 throughout.
//   2. Byte write 0x42 to 0x101 over 0xDEADBEEF, then half write 0x1234 to 0x102; word read 0x100
//      -> 0x12344 2EF (0x123442EF).
//   3. WAIT_STATES=3: single read -> HREADYOUT low for exactly 3 cycles, data on cycle 4;
//      an INCR4 burst takes 16 cycles total.
//   4. Back-to-back write then read to the same word with no IDLE gap -> the read returns the new data.
//      Addr MEM_BYTES+4 aliases to 0x4.
//   5. (AHB_SLV_ERR_RESP_EN) write to ERR_BASE -> HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1.
//      Memory is unchanged. Misaligned word read at 0x102 also returns ERROR.
//   6. Assert hresetn low during WAIT (WAIT_STATES=5) -> HREADYOUT=1 and HRESP=0 immediately.
//      The pending write is absent after reset; earlier data is retained.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the responder state type.
// Enum literals are prefixed so the transfer-type and state names can coexist in one scope.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } slv_state_e;

endpackage

// File: rtl/ahb_byte_lane_decode.sv
// Combinational HSIZE + HADDR[1:0] -> little-endian byte-lane mask and misalignment flag.
// Misaligned halfwords/words get the mask of their naturally aligned container.
module ahb_byte_lane_decode
    import ahb_pkg::*;
(
    input  logic [2:0] size_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] mask_o,
    output logic       misalign_o
);

    always_comb begin
        mask_o     = 4'hF;
        misalign_o = 1'b0;
        case (size_i)
            HSIZE_BYTE: mask_o = 4'b0001 << addr_lo_i;
            HSIZE_HALF: begin
                mask_o     = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                misalign_o = addr_lo_i[0];
            end
            default:    misalign_o = |addr_lo_i;
        endcase
    end

endmodule

// File: rtl/ahb_lite_sram_responder.sv
// AHB-Lite responder backed by a word-organised SRAM with programmable wait states.
// Optional ERROR responses for a window and misaligned beats under `AHB_SLV_ERR_RESP_EN.
module ahb_lite_sram_responder
    import ahb_pkg::*;
#(
    parameter int          MEM_BYTES   = 4096,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ERR_BASE    = 32'hF000,
    parameter int          ERR_BYTES   = 256
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int WORDS = MEM_BYTES / 4;
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    slv_state_e    state_q, state_d;
    logic [3:0]    wcnt_q, wcnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          write_q, write_d;
    logic [3:0]    mask_q, mask_d;

    logic [31:0]   mem [WORDS];

    logic [3:0]    lane_mask;
    logic          misalign;
    logic          accept;
    logic          bad_beat;
    logic [31:0]   word_addr;
    logic          unused_ok;

    ahb_byte_lane_decode u_lane (
        .size_i     (HSIZE),
        .addr_lo_i  (HADDR[1:0]),
        .mask_o     (lane_mask),
        .misalign_o (misalign)
    );

    assign accept    = HSEL & HREADY & HTRANS[1];
    // Word index wraps modulo the array size, so aliases above MEM_BYTES land in range.
    assign word_addr = (HADDR >> 2) & 32'(WORDS - 1);

`ifdef AHB_SLV_ERR_RESP_EN
    assign bad_beat  = misalign | ((HADDR - ERR_BASE) < 32'(ERR_BYTES));
    assign unused_ok = ^{HBURST, HPROT, HTRANS[0], word_addr};
`else
    assign bad_beat  = 1'b0;
    assign unused_ok = ^{HBURST, HPROT, HTRANS[0], word_addr, misalign, ERR_BASE, 32'(ERR_BYTES)};
`endif

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        mask_d  = mask_q;
        case (state_q)
            ST_WAIT: begin
                if (wcnt_q == 4'd0) state_d = ST_DATA;
                else                wcnt_d  = wcnt_q - 4'd1;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                // IDLE, DATA and ERR2 all present HREADYOUT=1, so each can take a new address phase.
                state_d = ST_IDLE;
                if (accept) begin
                    idx_d   = word_addr[IW-1:0];
                    mask_d  = lane_mask;
                    write_d = HWRITE & ~bad_beat;
                    if (bad_beat) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        wcnt_d  = 4'(WAIT_STATES - 1);
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 4'd0;
            idx_q   <= '0;
            write_q <= 1'b0;
            mask_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            mask_q  <= mask_d;
        end
    end

    // No reset on the array: contents survive hresetn.
    always_ff @(posedge hclk) begin
        if (state_q == ST_DATA && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (mask_q[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    assign HREADYOUT = !(state_q == ST_WAIT || state_q == ST_ERR1);
`ifdef AHB_SLV_ERR_RESP_EN
    assign HRESP     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
`else
    assign HRESP     = HRESP_OKAY;
`endif
    assign HRDATA    = (state_q == ST_DATA && !write_q) ? mem[idx_q] : 32'd0;

endmodule

// File: tb/tb_ahb_lite_sram_responder.sv
// Directed bench: a small pipelined AHB master drives one of three responders (0, 3 and 5 wait states).
module tb_ahb_lite_sram_responder;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    int          dsel = 0;
    logic [31:0] haddr = 32'd0;
    logic        hwrite = 1'b0;
    logic [1:0]  htrans = 2'd0;
    logic [2:0]  hsize = 3'd2;
    logic [31:0] hwdata = 32'd0;
    logic [2:0]  hburst = 3'd0;
    logic [3:0]  hprot = 4'd0;

    logic        ro [3];
    logic        rs [3];
    logic [31:0] rd [3];
    logic        hready, hresp;
    logic [31:0] hrdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] ba [8];
    logic [31:0] bd [8];
    logic        bw [8];
    logic [2:0]  bs [8];
    logic [31:0] rdat [8];
    logic        rresp [8];
    logic        rlow [8];
    int          lowc [8];
    int          cyc;

    always #5 hclk = ~hclk;

    assign hready = ro[dsel];
    assign hresp  = rs[dsel];
    assign hrdata = rd[dsel];

    ahb_lite_sram_responder #(.WAIT_STATES(0)) u_w0 (
        .hclk(hclk), .hresetn(hresetn), .HSEL(dsel == 0), .HADDR(haddr), .HWRITE(hwrite),
        .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
        .HREADY(hready), .HREADYOUT(ro[0]), .HRESP(rs[0]), .HRDATA(rd[0]));

    ahb_lite_sram_responder #(.WAIT_STATES(3)) u_w3 (
        .hclk(hclk), .hresetn(hresetn), .HSEL(dsel == 1), .HADDR(haddr), .HWRITE(hwrite),
        .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
        .HREADY(hready), .HREADYOUT(ro[1]), .HRESP(rs[1]), .HRDATA(rd[1]));

    ahb_lite_sram_responder #(.WAIT_STATES(5)) u_w5 (
        .hclk(hclk), .hresetn(hresetn), .HSEL(dsel == 2), .HADDR(haddr), .HWRITE(hwrite),
        .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
        .HREADY(hready), .HREADYOUT(ro[2]), .HRESP(rs[2]), .HRDATA(rd[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_beat(input int i, input logic w, input logic [31:0] a,
                            input logic [2:0] s, input logic [31:0] d);
        bw[i] = w; ba[i] = a; bs[i] = s; bd[i] = d;
    endtask

    // Address phase of beat i overlaps data phase of beat i-1; cyc counts data-phase cycles.
    task automatic pipe(input int n, input logic burst);
        logic done;
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            lowc[i] = 0; rlow[i] = 1'b0;
        end
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                htrans = (burst && i > 0) ? 2'd3 : 2'd2;
                haddr  = ba[i];
                hwrite = bw[i];
                hsize  = bs[i];
            end else begin
                htrans = 2'd0;
            end
            if (i > 0) hwdata = bd[i-1];
            done = 1'b0;
            for (int g = 0; g < 64 && !done; g++) begin
                @(negedge hclk);
                if (i > 0) cyc++;
                if (hready) begin
                    done = 1'b1;
                end else begin
                    if (i > 0) begin
                        lowc[i-1]++;
                        rlow[i-1] = hresp;
                    end
                    @(posedge hclk);
                end
            end
            assert (done) else begin
                errors++;
                $error("FAIL timeout: observed HREADYOUT stuck low expected high within 64 cycles");
            end
            if (i > 0) begin
                rdat[i-1]  = hrdata;
                rresp[i-1] = hresp;
            end
            @(posedge hclk);
            #1;
        end
    endtask

    initial begin
        dsel = 0;
        repeat (2) @(posedge hclk);
        #1;
        chk("reset_hreadyout", {31'd0, ro[0]}, 32'd1);
        chk("reset_hresp", {31'd0, rs[0]}, 32'd0);
        chk("reset_hrdata", rd[0], 32'd0);
        hresetn = 1'b1;
        @(posedge hclk);
        #1;

        // Zero wait states: write then read
        set_beat(0, 1'b1, 32'h100, 3'd2, 32'hDEADBEEF);
        set_beat(1, 1'b0, 32'h100, 3'd2, 32'h0);
        pipe(2, 1'b0);
        chk("t1_read", rdat[1], 32'hDEADBEEF);
        chk("t1_no_wait", lowc[0] + lowc[1], 32'd0);

        // Byte then halfword merge into the existing word
        set_beat(0, 1'b1, 32'h101, 3'd0, 32'h0000_4200);
        set_beat(1, 1'b1, 32'h102, 3'd1, 32'h1234_0000);
        set_beat(2, 1'b0, 32'h100, 3'd2, 32'h0);
        pipe(3, 1'b0);
        chk("t2_merge", rdat[2], 32'h123442EF);
        chk("t2_resp", {31'd0, rresp[2]}, 32'd0);

`ifndef AHB_SLV_ERR_RESP_EN
        // Misaligned beats fall back to the naturally aligned container
        set_beat(0, 1'b0, 32'h102, 3'd2, 32'h0);
        set_beat(1, 1'b1, 32'h103, 3'd1, 32'hAAAA_5566);
        set_beat(2, 1'b0, 32'h100, 3'd2, 32'h0);
        pipe(3, 1'b0);
        chk("mis_word_read", rdat[0], 32'h123442EF);
        chk("mis_half_write", rdat[2], 32'hAAAA42EF);
`endif

        // Back-to-back write/read, address aliasing, full-lane read for a byte access
        set_beat(0, 1'b1, 32'h200, 3'd2, 32'h55AA55AA);
        set_beat(1, 1'b0, 32'h200, 3'd2, 32'h0);
        set_beat(2, 1'b1, 32'h1004, 3'd2, 32'h0BADF00D);
        set_beat(3, 1'b0, 32'h4, 3'd2, 32'h0);
        set_beat(4, 1'b0, 32'h6, 3'd0, 32'h0);
        pipe(5, 1'b0);
        chk("t4_b2b", rdat[1], 32'h55AA55AA);
        chk("t4_alias", rdat[3], 32'h0BADF00D);
        chk("t4_byte_all_lanes", rdat[4], 32'h0BADF00D);

        // Three wait states
        dsel = 1;
        set_beat(0, 1'b1, 32'h20, 3'd2, 32'h01020304);
        pipe(1, 1'b0);
        set_beat(0, 1'b0, 32'h20, 3'd2, 32'h0);
        pipe(1, 1'b0);
        chk("t3_low_cycles", lowc[0], 32'd3);
        chk("t3_total_cycles", cyc, 32'd4);
        chk("t3_read", rdat[0], 32'h01020304);
        for (int i = 0; i < 4; i++) set_beat(i, 1'b1, 32'h30 + 32'(4*i), 3'd2, 32'hA0000000 + 32'(i));
        pipe(4, 1'b1);
        chk("t3_wburst_cycles", cyc, 32'd16);
        for (int i = 0; i < 4; i++) set_beat(i, 1'b0, 32'h30 + 32'(4*i), 3'd2, 32'h0);
        pipe(4, 1'b1);
        chk("t3_rburst_cycles", cyc, 32'd16);
        chk("t3_rburst_beat1", rdat[1], 32'hA0000001);
        chk("t3_rburst_beat3", rdat[3], 32'hA0000003);

        // Reset in the middle of a waited write
        dsel = 2;
        set_beat(0, 1'b1, 32'h10, 3'd2, 32'hCAFEF00D);
        pipe(1, 1'b0);
        haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2; htrans = 2'd2;
        @(posedge hclk);
        #1;
        htrans = 2'd0;
        hwdata = 32'h11111111;
        @(posedge hclk);
        #1;
        chk("t6_in_wait", {31'd0, ro[2]}, 32'd0);
        #2;
        hresetn = 1'b0;
        #1;
        chk("t6_rst_hreadyout", {31'd0, ro[2]}, 32'd1);
        chk("t6_rst_hresp", {31'd0, rs[2]}, 32'd0);
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
        @(posedge hclk);
        #1;
        set_beat(0, 1'b0, 32'h10, 3'd2, 32'h0);
        pipe(1, 1'b0);
        chk("t6_retained", rdat[0], 32'hCAFEF00D);
        chk("t6_full_waits", lowc[0], 32'd5);

`ifdef AHB_SLV_ERR_RESP_EN
        dsel = 0;
        set_beat(0, 1'b1, 32'h0, 3'd2, 32'h13572468);
        set_beat(1, 1'b1, 32'hF000, 3'd2, 32'h99999999);
        set_beat(2, 1'b0, 32'h0, 3'd2, 32'h0);
        set_beat(3, 1'b0, 32'h102, 3'd2, 32'h0);
        pipe(4, 1'b0);
        chk("err_low_cycles", lowc[1], 32'd1);
        chk("err_resp_low", {31'd0, rlow[1]}, 32'd1);
        chk("err_resp_final", {31'd0, rresp[1]}, 32'd1);
        chk("err_mem_unchanged", rdat[2], 32'h13572468);
        chk("err_misalign_resp", {31'd0, rresp[3]}, 32'd1);
        chk("err_misalign_data", rdat[3], 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
